// File: rtl/key_expr_parser.sv
// Keystroke expression parser: assembles "A op B<Enter>" from UART bytes
// and hands operands plus operator to the calculator core. Malformed input
// raises a one-cycle parse_error with a sticky err_code; Esc aborts silently.
module key_expr_parser #(
    parameter int DIGITS = 4,
    parameter int OPW    = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [OPW-1:0]  operand_a,
    output logic [OPW-1:0]  operand_b,
    output logic [1:0]      op_code,
    output logic            expr_valid,
    output logic            parse_error,
    output logic [1:0]      err_code
);

    localparam int CNTW = $clog2(DIGITS + 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(DIGITS);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [OPW-1:0]  ACC_ZERO = {OPW{1'b0}};

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIGITS  = 2'b10;
    localparam logic [1:0] ERR_SEQ     = 2'b11;

    typedef enum logic [0:0] {
        ST_A = 1'b0,
        ST_B = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        CL_DIGIT = 3'd0,
        CL_OP    = 3'd1,
        CL_ENTER = 3'd2,
        CL_SPACE = 3'd3,
        CL_ESC   = 3'd4,
        CL_OTHER = 3'd5
    } byte_class_t;

    state_t          state_q,       state_d;
    logic [OPW-1:0]  acc_q,         acc_d;
    logic [CNTW-1:0] cnt_q,         cnt_d;
    logic [OPW-1:0]  a_q,           a_d;
    logic [1:0]      op_q,          op_d;
    logic [OPW-1:0]  operand_a_q,   operand_a_d;
    logic [OPW-1:0]  operand_b_q,   operand_b_d;
    logic [1:0]      op_code_q,     op_code_d;
    logic            expr_valid_q,  expr_valid_d;
    logic            parse_error_q, parse_error_d;
    logic [1:0]      err_code_q,    err_code_d;

    byte_class_t     cls_s;
    logic [1:0]      op_sel_s;
    logic [OPW-1:0]  acc_x10_s;
    logic [OPW-1:0]  acc_ins_s;
    logic            err_hit_s;
    logic [1:0]      err_val_s;

    // Classify the incoming byte and decode the operator code.
    always_comb begin
        cls_s    = CL_OTHER;
        op_sel_s = 2'b00;
        if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
            cls_s = CL_DIGIT;
        end else begin
            case (rx_data)
                8'h2B: begin cls_s = CL_OP; op_sel_s = 2'b00; end
                8'h2D: begin cls_s = CL_OP; op_sel_s = 2'b01; end
                8'h2A: begin cls_s = CL_OP; op_sel_s = 2'b10; end
                8'h2F: begin cls_s = CL_OP; op_sel_s = 2'b11; end
                8'h0D: cls_s = CL_ENTER;
                8'h20: cls_s = CL_SPACE;
                8'h1B: cls_s = CL_ESC;
                default: cls_s = CL_OTHER;
            endcase
        end
    end

    // Decimal accumulate: acc*10 as two shifts, truncated to the operand width.
    always_comb begin
        acc_x10_s = (acc_q << 3) + (acc_q << 1);
        acc_ins_s = acc_x10_s + {{(OPW-4){1'b0}}, rx_data[3:0]};
    end

    // Next-state and registered-output logic for the parser.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        op_d          = op_q;
        operand_a_d   = operand_a_q;
        operand_b_d   = operand_b_q;
        op_code_d     = op_code_q;
        expr_valid_d  = 1'b0;
        parse_error_d = 1'b0;
        err_code_d    = err_code_q;
        err_hit_s     = 1'b0;
        err_val_s     = ERR_ILLEGAL;

        if (rx_valid) begin
            case (cls_s)
                CL_DIGIT: begin
                    if (cnt_q < CNT_MAX) begin
                        acc_d = acc_ins_s;
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        err_hit_s = 1'b1;
                        err_val_s = ERR_DIGITS;
                    end
                end
                CL_OP: begin
                    if ((state_q == ST_A) && (cnt_q != CNT_ZERO)) begin
                        a_d     = acc_q;
                        op_d    = op_sel_s;
                        acc_d   = ACC_ZERO;
                        cnt_d   = CNT_ZERO;
                        state_d = ST_B;
                    end else begin
                        err_hit_s = 1'b1;
                        err_val_s = ERR_SEQ;
                    end
                end
                CL_ENTER: begin
                    if ((state_q == ST_B) && (cnt_q != CNT_ZERO)) begin
                        operand_a_d  = a_q;
                        operand_b_d  = acc_q;
                        op_code_d    = op_q;
                        expr_valid_d = 1'b1;
                        acc_d        = ACC_ZERO;
                        cnt_d        = CNT_ZERO;
                        state_d      = ST_A;
                    end else begin
                        err_hit_s = 1'b1;
                        err_val_s = ERR_SEQ;
                    end
                end
                CL_SPACE: begin
                    state_d = state_q;
                end
                CL_ESC: begin
                    acc_d   = ACC_ZERO;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_A;
                end
                default: begin
                    err_hit_s = 1'b1;
                    err_val_s = ERR_ILLEGAL;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Any error discards the partial expression but keeps the last result.
        if (err_hit_s) begin
            parse_error_d = 1'b1;
            err_code_d    = err_val_s;
            acc_d         = ACC_ZERO;
            cnt_d         = CNT_ZERO;
            state_d       = ST_A;
        end else begin
            parse_error_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_A;
            acc_q         <= ACC_ZERO;
            cnt_q         <= CNT_ZERO;
            a_q           <= ACC_ZERO;
            op_q          <= 2'b00;
            operand_a_q   <= ACC_ZERO;
            operand_b_q   <= ACC_ZERO;
            op_code_q     <= 2'b00;
            expr_valid_q  <= 1'b0;
            parse_error_q <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            op_q          <= op_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            op_code_q     <= op_code_d;
            expr_valid_q  <= expr_valid_d;
            parse_error_q <= parse_error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign op_code     = op_code_q;
    assign expr_valid  = expr_valid_q;
    assign parse_error = parse_error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_key_expr_parser.sv
// Bench for key_expr_parser: directed keystroke scenarios followed by
// random keystroke streams, each output compared every cycle against a
// character-queue model of the expression grammar.
module tb_key_expr_parser;

    localparam int DIGITS = 4;
    localparam int OPW    = 14;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [OPW-1:0] operand_a;
    logic [OPW-1:0] operand_b;
    logic [1:0]     op_code;
    logic           expr_valid;
    logic           parse_error;
    logic [1:0]     err_code;

    key_expr_parser #(.DIGITS(DIGITS), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_code    (op_code),
        .expr_valid (expr_valid),
        .parse_error(parse_error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "reset";

    // Reference model state: characters of the pending expression (no spaces).
    byte unsigned line_q[$];
    int exp_a = 0, exp_b = 0, exp_op = 0, exp_ev = 0, exp_pe = 0, exp_err = 0;

    byte unsigned pool[14] = '{8'h30, 8'h31, 8'h35, 8'h39, 8'h2B, 8'h2D, 8'h2A,
                               8'h2F, 8'h0D, 8'h20, 8'h1B, 8'h78, 8'h3A, 8'h2F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_digit(input byte unsigned c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic int op_of(input byte unsigned c);
        case (c)
            8'h2B:   return 0;
            8'h2D:   return 1;
            8'h2A:   return 2;
            8'h2F:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_err(input int code);
        exp_pe  = 1;
        exp_err = code;
        line_q.delete();
    endtask

    // Grammar: [0-9]{1,DIGITS} op [0-9]{1,DIGITS} Enter, spaces ignored.
    task automatic model_byte(input byte unsigned c);
        int opi, trail, a, b;
        exp_ev = 0;
        exp_pe = 0;
        opi = -1;
        foreach (line_q[i]) if (!is_digit(line_q[i])) opi = i;
        trail = line_q.size() - opi - 1;
        if (c == 8'h20) begin
        end else if (c == 8'h1B) begin
            line_q.delete();
        end else if (is_digit(c)) begin
            if (trail >= DIGITS) model_err(2);
            else line_q.push_back(c);
        end else if (op_of(c) >= 0) begin
            if (line_q.size() > 0 && opi < 0) line_q.push_back(c);
            else model_err(3);
        end else if (c == 8'h0D) begin
            if (opi >= 0 && trail >= 1) begin
                a = 0;
                b = 0;
                for (int i = 0; i < opi; i++) a = a * 10 + (line_q[i] - 8'h30);
                for (int i = opi + 1; i < line_q.size(); i++) b = b * 10 + (line_q[i] - 8'h30);
                exp_a  = a % (1 << OPW);
                exp_b  = b % (1 << OPW);
                exp_op = op_of(line_q[opi]);
                exp_ev = 1;
                line_q.delete();
            end else begin
                model_err(3);
            end
        end else begin
            model_err(1);
        end
    endtask

    // Check outputs produced by the previous cycle, then apply new inputs.
    task automatic step(input bit rst, input bit v, input byte unsigned d);
        @(negedge clk);
        check("operand_a",   32'(operand_a),   32'(exp_a));
        check("operand_b",   32'(operand_b),   32'(exp_b));
        check("op_code",     32'(op_code),     32'(exp_op));
        check("expr_valid",  32'(expr_valid),  32'(exp_ev));
        check("parse_error", 32'(parse_error), 32'(exp_pe));
        check("err_code",    32'(err_code),    32'(exp_err));
        reset    = rst;
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        if (rst) begin
            line_q.delete();
            exp_a = 0; exp_b = 0; exp_op = 0; exp_ev = 0; exp_pe = 0; exp_err = 0;
        end else if (v) begin
            model_byte(d);
        end else begin
            exp_ev = 0;
            exp_pe = 0;
        end
    endtask

    task automatic send_byte(input byte unsigned c, input int gap);
        step(1'b0, 1'b1, c);
        repeat (gap) step(1'b0, 1'b0, 8'h00);
    endtask

    // '~' stands for Enter and '!' for Esc in directed strings.
    task automatic send_str(input string s, input int gap);
        byte unsigned c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7E) c = 8'h0D;
            else if (c == 8'h21) c = 8'h1B;
            send_byte(c, gap);
        end
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_num(input int nd, input int gap);
        for (int i = 0; i < nd; i++) send_byte(8'(8'h30 + $urandom_range(0, 9)), gap);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        phase = "T1"; send_str("12+34~", 1);
        phase = "T2"; send_str("9999*9999~", 0);
        phase = "T3"; send_str("12345", 0); send_str("7/2~", 2);
        phase = "T4"; send_str("+5~", 0); send_str("5~", 1); send_str("5x", 0);
        phase = "T5"; send_str("1 2 - 3 ~", 0); send_str("45-6!8+1~", 0);
        phase = "T6"; send_str("12+3", 0);
        step(1'b1, 1'b0, 8'h00);
        send_str("~", 0);

        phase = "rand";
        for (int it = 0; it < 400; it++) begin
            int r, gap;
            r   = $urandom_range(0, 9);
            gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (r <= 4) begin
                send_num($urandom_range(1, DIGITS), gap);
                if ($urandom_range(0, 3) == 0) send_byte(8'h20, gap);
                send_byte(pool[$urandom_range(4, 7)], gap);
                send_num($urandom_range(1, DIGITS), gap);
                send_byte(8'h0D, gap);
            end else if (r <= 6) begin
                send_byte(pool[$urandom_range(0, 13)], gap);
            end else if (r == 7) begin
                send_byte(8'($urandom), gap);
            end else if (r == 8) begin
                send_num($urandom_range(1, DIGITS + 2), gap);
            end else begin
                step(1'b1, 1'b0, 8'h00);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
